bg_draw_scheduler: RTL

Sequences the single VGA pixel-write port between full-screen background redraws and small solid-colour sprite (note/drum-hit) draws. It generates the linear address for the 160x120 background ROMs and latches the screen-select code that drives the external background colour mux. It then streams ROM pixels out as plot strobes and arbitrates pending sprite requests onto the same port. It sits between game-state control and the VGA adapter.

---
 rtl/bg_draw_scheduler_pkg.sv | 39 +++
 rtl/bg_scan_counter.sv | 52 +++++
 rtl/bg_draw_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bg_draw_scheduler_pkg.sv
// Shared constants, state encoding and screen codes for the background/sprite draw scheduler.
package bg_draw_scheduler_pkg;

    localparam int SCR_W      = 160;
    localparam int SCR_H      = 120;
    localparam int SCR_PIXELS = SCR_W * SCR_H;
    localparam int SPR_W      = 8;
    localparam int SPR_H      = 8;
    localparam int SPR_PIXELS = SPR_W * SPR_H;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BG_FILL  = 2'd1,
        SPR_DRAW = 2'd2
    } draw_state_e;

    typedef enum logic [3:0] {
        GAME1        = 4'd0,
        GAME2        = 4'd1,
        GAME3        = 4'd2,
        GAME4        = 4'd3,
        GAME5        = 4'd4,
        GAME6        = 4'd5,
        START        = 4'd6,
        START_LETTER = 4'd7
    } screen_code_e;

    // Codes above the last defined screen fall back to the first game screen.
    function automatic logic [3:0] legal_screen(input logic [3:0] code);
        logic [3:0] res;
        if (code > START_LETTER) begin
            res = GAME1;
        end else begin
            res = code;
        end
        return res;
    endfunction

endpackage

// File: rtl/bg_scan_counter.sv
// Raster walker: x inner loop, y outer loop, plus a running linear address
// so no multiplier is needed to form y*W+x.
module bg_scan_counter #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr
);

    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [AW-1:0] A_ONE  = AW'(1);

    // Advance the walk one pixel per enabled cycle, wrapping to the origin after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y    <= '0;
                    addr <= '0;
                end else begin
                    y    <= y + Y_ONE;
                    addr <= addr + A_ONE;
                end
            end else begin
                x    <= x + X_ONE;
                addr <= addr + A_ONE;
            end
        end
    end

endmodule

// File: rtl/bg_draw_scheduler.sv
// Shares the single VGA write port between full-screen background fills streamed
// from a synchronous ROM and small solid-colour sprite draws.
module bg_draw_scheduler
    import bg_draw_scheduler_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        bg_req,
    input  logic [3:0]  screen_sel,
    input  logic        spr_req,
    input  logic [7:0]  spr_x,
    input  logic [6:0]  spr_y,
    input  logic [2:0]  spr_color,
    input  logic [2:0]  rom_color,
    output logic [3:0]  bg_sel,
    output logic [14:0] rom_addr,
    output logic        spr_ack,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        vga_plot,
    output logic        busy,
    output logic        done
);

    localparam logic [14:0] BG_LAST  = 15'(SCR_PIXELS - 1);
    localparam logic [5:0]  SPR_LAST = 6'(SPR_PIXELS - 1);

    draw_state_e state_r, state_nx_s;
    logic        bg_pend_r, bg_pend_nx_s;
    logic        tail_r, tail_nx_s;
    logic        src_bg_r;
    logic [7:0]  spr_x_r;
    logic [6:0]  spr_y_r;
    logic [2:0]  spr_c_r;

    logic        cnt_clr_s, bg_en_s, spr_en_s;
    logic        start_bg_s, start_spr_s, done_nx_s, ack_nx_s;
    logic [7:0]  bg_x_s;
    logic [6:0]  bg_y_s;
    logic [14:0] bg_addr_s;
    logic [2:0]  spr_dx_s, spr_dy_s;
    logic [5:0]  spr_addr_s;
    logic [8:0]  spr_sx_s;
    logic [7:0]  spr_sy_s;
    logic        spr_in_s;

    bg_scan_counter #(.W(SCR_W), .H(SCR_H), .XW(8), .YW(7), .AW(15)) u_bg_scan (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .clear (cnt_clr_s),
        .en    (bg_en_s),
        .x     (bg_x_s),
        .y     (bg_y_s),
        .addr  (bg_addr_s)
    );

    bg_scan_counter #(.W(SPR_W), .H(SPR_H), .XW(3), .YW(3), .AW(6)) u_spr_scan (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .clear (cnt_clr_s),
        .en    (spr_en_s),
        .x     (spr_dx_s),
        .y     (spr_dy_s),
        .addr  (spr_addr_s)
    );

    assign rom_addr = bg_addr_s;

    // Sprite pixel position, widened by one bit so edge sprites clip instead of wrapping.
    always_comb begin
        spr_sx_s = {1'b0, spr_x_r} + {6'd0, spr_dx_s};
        spr_sy_s = {1'b0, spr_y_r} + {5'd0, spr_dy_s};
        spr_in_s = (spr_sx_s < 9'(SCR_W)) && (spr_sy_s < 8'(SCR_H));
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; tail marks the one drain cycle after the last pixel is issued.
    always_comb begin
        state_nx_s   = state_r;
        tail_nx_s    = tail_r;
        done_nx_s    = 1'b0;
        ack_nx_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        bg_en_s      = 1'b0;
        spr_en_s     = 1'b0;
        start_bg_s   = 1'b0;
        start_spr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                tail_nx_s = 1'b0;
                if (bg_pend_r || bg_req) begin
                    state_nx_s = BG_FILL;
                    start_bg_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                end else if (spr_req) begin
                    state_nx_s  = SPR_DRAW;
                    start_spr_s = 1'b1;
                    ack_nx_s    = 1'b1;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BG_FILL: begin
                if (tail_r) begin
                    state_nx_s = IDLE;
                    done_nx_s  = 1'b1;
                    tail_nx_s  = 1'b0;
                end else begin
                    bg_en_s   = 1'b1;
                    tail_nx_s = (bg_addr_s == BG_LAST);
                end
            end
            SPR_DRAW: begin
                if (tail_r) begin
                    state_nx_s = IDLE;
                    done_nx_s  = 1'b1;
                    tail_nx_s  = 1'b0;
                end else begin
                    spr_en_s  = 1'b1;
                    tail_nx_s = (spr_addr_s == SPR_LAST);
                end
            end
            default: begin
                state_nx_s = IDLE;
                tail_nx_s  = 1'b0;
                cnt_clr_s  = 1'b1;
            end
        endcase
    end

    // Background requests collapse into one pending flag, consumed when a fill starts.
    always_comb begin
        bg_pend_nx_s = (bg_pend_r | bg_req) & ~start_bg_s;
    end

    // Control flags, request captures and registered status strobes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bg_pend_r <= 1'b0;
            tail_r    <= 1'b0;
            src_bg_r  <= 1'b0;
            bg_sel    <= 4'd0;
            spr_x_r   <= 8'd0;
            spr_y_r   <= 7'd0;
            spr_c_r   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spr_ack   <= 1'b0;
        end else begin
            bg_pend_r <= bg_pend_nx_s;
            tail_r    <= tail_nx_s;
            busy      <= (state_nx_s != IDLE);
            done      <= done_nx_s;
            spr_ack   <= ack_nx_s;
            if (start_bg_s) begin
                bg_sel   <= legal_screen(screen_sel);
                src_bg_r <= 1'b1;
            end else if (start_spr_s) begin
                spr_x_r  <= spr_x;
                spr_y_r  <= spr_y;
                spr_c_r  <= spr_color;
                src_bg_r <= 1'b0;
            end
        end
    end

    // Plot strobe and coordinates, one stage behind the walkers to line up with the ROM read.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vga_plot <= 1'b0;
            vga_x    <= 8'd0;
            vga_y    <= 7'd0;
        end else if (bg_en_s) begin
            vga_plot <= 1'b1;
            vga_x    <= bg_x_s;
            vga_y    <= bg_y_s;
        end else if (spr_en_s) begin
            vga_plot <= spr_in_s;
            if (spr_in_s) begin
                vga_x <= spr_sx_s[7:0];
                vga_y <= spr_sy_s[6:0];
            end
        end else begin
            vga_plot <= 1'b0;
        end
    end

    // Background pixels come straight from the ROM, which already lags the address by one cycle.
    always_comb begin
        if (src_bg_r) begin
            vga_color = rom_color;
        end else begin
            vga_color = spr_c_r;
        end
    end

endmodule
